// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider: one radix-2 restoring step per cycle,
// result = {remainder, quotient}, held until the requester drops start.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic        annul,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall_div
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic           ready_q, ready_d;
  logic [2*W-1:0] result_q, result_d;

  // Restoring step: quo_q holds the not-yet-consumed dividend bits, shifted out MSB first
  logic [W:0]   shifted, diff;
  logic         step_ok;
  logic [W-1:0] rem_step, quo_step, rem_fix, quo_fix;
  logic [W-1:0] a_abs, b_abs;

  assign shifted  = {rem_q, quo_q[W-1]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign step_ok  = ~diff[W];
  assign rem_step = step_ok ? diff[W-1:0] : shifted[W-1:0];
  assign quo_step = {quo_q[W-2:0], step_ok};
  assign quo_fix  = neg_quo_q ? (-quo_step) : quo_step;
  assign rem_fix  = neg_rem_q ? (-rem_step) : rem_step;

  // Magnitudes wrap modulo 2^32, so abs(0x80000000) stays 0x80000000 as an unsigned value
  assign a_abs = (signed_div && opdata1[W-1]) ? (-opdata1) : opdata1;
  assign b_abs = (signed_div && opdata2[W-1]) ? (-opdata2) : opdata2;

  assign result    = result_q;
  assign ready     = ready_q;
  assign stall_div = start & (state_q != END);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = ready_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start && !annul) begin
          rem_d     = '0;
          quo_d     = a_abs;
          dvs_d     = b_abs;
          neg_quo_d = signed_div & (opdata1[W-1] ^ opdata2[W-1]);
          neg_rem_d = signed_div & opdata1[W-1];
          cnt_d     = '0;
          state_d   = (opdata2 == '0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          rem_d    = '0;
          quo_d    = '0;
          ready_d  = 1'b1;
          result_d = '0;
          state_d  = END;
        end
      end
      ON: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            ready_d  = 1'b1;
            result_d = {rem_fix, quo_fix};
            state_d  = END;
          end
        end
      end
      END: begin
        if (annul || !start) begin
          ready_d  = 1'b0;
          result_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: stimulus pushes expected results, a negedge monitor
// pops and compares on each rising ready; the stimulus side checks timing and handshake.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, signed_div, annul;
  logic [31:0] opdata1, opdata2;
  logic [63:0] result;
  logic        ready, stall_div;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];
  logic ready_prev = 1'b0;

  div_unit dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
    .opdata1(opdata1), .opdata2(opdata2), .result(result), .ready(ready),
    .stall_div(stall_div)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every new ready must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (ready && !ready_prev) begin
      if (exp_q.size() == 0) chk("unexpected_ready", 64'd1, 64'd0);
      else chk("result", result, exp_q.pop_front());
    end
    ready_prev <= ready;
  end

  task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic [63:0] exp, input int lat, input int hold);
    int k;
    @(negedge clk);
    opdata1 = a; opdata2 = b; signed_div = sg; start = 1'b1;
    exp_q.push_back(exp);
    #1 chk({name, "_stall_c0"}, 64'(stall_div), 64'd1);
    k = 0;
    while (k < lat + 5) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        opdata1 = 32'hDEAD_BEEF; opdata2 = 32'h0; signed_div = ~sg;
      end
      if (ready) break;
      if (k < lat) begin
        vectors++;
        if (stall_div !== 1'b1) begin
          miscompares++;
          $display("FAIL %s_stall_busy: got %b expected 1 at cycle %0d", name, stall_div, k);
        end
      end
    end
    chk({name, "_latency"}, 64'(k), 64'(lat));
    chk({name, "_stall_done"}, 64'(stall_div), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, "_hold_ready"}, 64'(ready), 64'd1);
      chk({name, "_hold_result"}, result, exp);
    end
    start = 1'b0;
    @(negedge clk);
    chk({name, "_drop_ready"}, 64'(ready), 64'd0);
    chk({name, "_drop_result"}, result, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_stall", 64'(stall_div), 64'd0);
    rst = 1'b0;

    do_div("udiv_100_7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 0);
    do_div("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
    do_div("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h1, 32'hFFFF_FFFD}, 33, 0);
    do_div("div_zero", 32'd5, 32'd0, 1'b0, 64'd0, 2, 0);
    do_div("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33, 0);

    // Annul at cycle 10 of ON: no result may ever appear
    @(negedge clk);
    opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i % 10 == 0) chk("annul_no_ready", 64'(ready), 64'd0);
    end
    do_div("udiv_after_annul", 32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF}, 33, 0);

    do_div("hold3", 32'd1234567, 32'd1000, 1'b0, {32'd567, 32'd1234}, 33, 3);
    do_div("restart", 32'd81, 32'd9, 1'b0, {32'd0, 32'd9}, 33, 0);

    // Reset at cycle 20 of ON
    @(negedge clk);
    opdata1 = 32'd500; opdata2 = 32'd4; signed_div = 1'b0; start = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(ready), 64'd0);
    chk("midrst_result", result, 64'd0);
    rst = 1'b0;
    repeat (35) @(negedge clk);
    chk("midrst_quiet", 64'(ready), 64'd0);
    start = 1'b1;
    #1 chk("rst_stall_follow", 64'(stall_div), 64'd1);
    start = 1'b0;
    #1 chk("rst_stall_low", 64'(stall_div), 64'd0);
    do_div("after_rst", 32'hFFFF_FF9C, 32'd7, 1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  divide request, held high by the pipeline until ready is seen.
REQ-005 signed_div  input  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled with start in IDLE.
REQ-006 annul  input  1  pipeline flush; aborts any operation in progress.
REQ-007 opdata1  input  32  dividend (rs); sampled with start in IDLE.
REQ-008 opdata2  input  32  divisor (rt); sampled with start in IDLE.
REQ-009 result  output  64  {hi = remainder, lo = quotient}.
REQ-010 ready  output  1  result valid.
REQ-011 stall_div  output  1  pipeline stall request.

Function
REQ-012 The block SHALL implement a four-state FSM: IDLE, BYZERO, ON, END.
REQ-013 IDLE SHALL behave as follows:
- start=1 and annul=0: latch the operands and signed_div.
- Divisor == 0: go to BYZERO.
- Divisor != 0: go to ON with the iteration counter at 0.
- Otherwise: stay in IDLE with ready=0 and result=0.
REQ-014 BYZERO SHALL set the internal quotient and remainder to 0 and go to END on the next edge.
REQ-015 ON SHALL perform one radix-2 restoring step per cycle:
- Shift {remainder, quotient} left by 1.
- Trial-subtract the 33-bit divisor.
- Set the quotient bit if the result is non-negative, otherwise keep the old remainder.
REQ-016 ON SHALL run exactly 32 iterations (counter 0..31) and then go to END.
REQ-017 Total latency SHALL be 33 cycles for a normal divide:
- start sampled at cycle 0; ON occupies cycles 1..32; ready=1 first at cycle 33.
- Divide by zero: ready=1 at cycle 2.
REQ-018 Signed mode SHALL divide the absolute values.
REQ-019 Signed mode SHALL negate the quotient when the operand signs differ.
REQ-020 Signed mode SHALL give the remainder the sign of the dividend.
REQ-021 All signed arithmetic SHALL be modulo 2^32; 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-022 END SHALL drive ready=1 and result={remainder, quotient}.
REQ-023 END SHALL hold ready and result while start=1.
REQ-024 END SHALL go to IDLE on the first edge with start=0; ready and result SHALL read 0 from that edge.
REQ-025 A start that is still high in END SHALL NOT launch a new divide; start must drop to 0 first.
REQ-026 annul=1 in BYZERO or ON SHALL return the FSM to IDLE on the next edge, discarding the result; ready SHALL stay 0.
REQ-027 annul=1 together with start=1 in IDLE SHALL NOT launch a divide.
REQ-028 annul=1 in END SHALL return the FSM to IDLE.
REQ-029 stall_div SHALL be a combinational output equal to start AND NOT(state==END).
REQ-030 Operand changes after sampling SHALL NOT affect an operation in progress.

Reset
REQ-031 rst=1 SHALL force, on the next edge: state IDLE, counter 0, internal registers 0, ready=0, result=0.
REQ-032 rst SHALL override start and annul, including mid-operation.
REQ-033 After reset, stall_div SHALL follow start.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Unsigned: opdata1=100, opdata2=7, signed_div=0, start held -> ready first at cycle 33; result lo=0x0000000E, hi=0x00000002; stall_div=1 on cycles 0..32 and 0 at cycle 33.
- Signed: opdata1=0xFFFFFFF9 (-7), opdata2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 7 / 0xFFFFFFFE -> lo=0xFFFFFFFD, hi=0x00000001.
- Divide by zero and overflow: opdata2=0 -> ready at cycle 2, result=0. Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Annul: annul pulsed at cycle 10 of ON -> IDLE next edge, ready never asserted. A fresh start of 0xFFFFFFFF / 0x10 unsigned -> lo=0x0FFFFFFF, hi=0xF after 33 cycles.
- Handshake: start held 3 cycles past ready -> result stable. After start drops -> ready=0 next edge. Re-raising start -> new full 33-cycle divide.
- Reset: rst asserted at cycle 20 of ON -> IDLE next edge, ready=0, result=0. The next divide completes correctly.
